vc_read_arbiter: RTL and testbench
==================================

# vc_read_arbiter

Read-side controller for the two virtual-channel FIFOs (VC0, VC1) of the transmission path. It issues read enables to the FIFOs and applies strict priority to VC0. It honours downstream backpressure, realigns each FIFO's one-cycle registered read data, and presents a single registered word stream with a valid strobe to the next stage.

## Interface
Parameters:
- data_width, 6, width of each FIFO word and of data_out.
- MAX_BURST, 4, maximum consecutive VC0 grants while VC1 is non-empty; used only when VC_FAIR_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; all registers cleared immediately when low.
- init  input  1  synchronous soft init, active-low; forces INIT state.
- empty_VC0, empty_VC1  input  1 each  empty flags from the FIFOs.
- data_in_VC0, data_in_VC1  input  data_width each  registered read data from the FIFOs, valid the cycle after their rd_enable.
- almost_full_dest  input  1  downstream backpressure; 1 blocks new reads.
- rd_enable_VC0, rd_enable_VC1  output  1 each  combinational FIFO read strobes; never both 1.
- data_out  output  data_width  registered output word.
- valid_out  output  1  registered; 1 when data_out holds a new word.
- state  output  2  current FSM state.

## Operation
- States: RESET=2'd0, INIT=2'd1, IDLE=2'd2, ACTIVE=2'd3.
- Transitions:
  - reset low forces RESET asynchronously.
  - RESET always moves to INIT on the next edge.
  - From any state, init==0 forces INIT.
  - INIT moves to IDLE when init==1.
  - From IDLE or ACTIVE, the next state is ACTIVE if a read strobe is asserted this cycle, otherwise IDLE.
- Read grant is combinational and only allowed in IDLE/ACTIVE with init==1 and almost_full_dest==0:
  - rd_enable_VC0 = !empty_VC0.
  - rd_enable_VC1 = empty_VC0 && !empty_VC1.
- Pipeline:
  - Stage 1 registers pend_q (a read was issued) and sel_q (which VC was read).
  - Stage 2 registers data_out from data_in_VC0 or data_in_VC1 according to sel_q, and sets valid_out=pend_q.
- When pend_q==0, data_out holds its previous value and valid_out=0.
- Backpressure blocks only new reads. Up to 2 words already in flight still emerge. The downstream almost_full threshold must leave at least 2 entries of slack.
- init==0 clears pend_q, sel_q, data_out and valid_out on the next edge. In-flight words are discarded, consistent with the FIFOs flushing on init.
- Empty flags update the cycle after a read. Back-to-back reads down to the last entry are therefore legal, and the design never reads an empty FIFO.

## Timing
- Reset values: rd_enable_VC0=0, rd_enable_VC1=0, data_out=0, valid_out=0, state=RESET, pend_q=0, sel_q=0, burst counter=0.
- Latency: a read strobe in cycle T produces valid_out=1 with the word in cycle T+2.
- Throughput: 1 word/cycle sustained while there is data and no backpressure.
- Backpressure: almost_full_dest rising in cycle T blocks reads in cycle T. valid_out may still be 1 in cycles T and T+1 from earlier reads.
- Reset asserted mid-stream clears all outputs in the same cycle, without waiting for clk.

## Configuration
- Macro: VC_FAIR_EN.
- Defined:
  - A 3-bit burst counter counts consecutive VC0 grants while empty_VC1==0.
  - When the counter reaches MAX_BURST and VC1 is non-empty, the next grant goes to VC1 and the counter clears.
  - The counter also clears on any VC1 grant, on any cycle with empty_VC1==1, and on INIT.
- Undefined: strict VC0 priority. VC1 may starve indefinitely. No counter logic is present.

## Test plan
- Reset/init: hold reset low 3 cycles, then init low 2 cycles -> all outputs 0. state goes 0, 1, then 2 the cycle after init returns high.
- Single VC1 word: empty_VC1 falls with data 6'h2A -> rd_enable_VC1 for exactly 1 cycle. data_out=6'h2A with valid_out=1 two cycles later, then valid_out=0.
- Priority: both FIFOs hold 3 words -> 3 VC0 reads, then 3 VC1 reads (non-fair build). valid_out stays high for 6 consecutive cycles.
- Backpressure: almost_full_dest high mid-stream for 4 cycles -> reads stop that cycle. Exactly 2 trailing valid words appear, then none until release. No word is lost or duplicated.
- Fair mode (VC_FAIR_EN, MAX_BURST=4): VC0 holds 10 words, VC1 holds 2 -> grant order 0,0,0,0,1,0,0,0,0,1,0,0.
- Init mid-stream: init low while 2 words are in flight -> valid_out=0 from the next edge and state=INIT. No stale word appears after init returns high.

Source files
------------

// File: rtl/vc_read_arbiter.sv
// vc_read_arbiter
// Read-side controller for the two virtual-channel FIFOs of the transmit path.
// It issues combinational read strobes with VC0 priority and honours downstream
// backpressure. It realigns the FIFOs' one-cycle registered read data and
// presents a registered word stream with a valid strobe.
//
// Optional feature: define VC_FAIR_EN to bound VC0 bursts to MAX_BURST grants
// while VC1 has data. Without it, VC0 has strict priority and VC1 may starve.
//
// Backpressure only stops new reads. Up to two words already in flight still
// emerge, so the downstream almost_full threshold needs at least two entries of
// slack.

module vc_read_arbiter #(
  parameter int data_width = 6,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_VC0,
  input  logic                  empty_VC1,
  input  logic [data_width-1:0] data_in_VC0,
  input  logic [data_width-1:0] data_in_VC1,
  input  logic                  almost_full_dest,
  output logic                  rd_enable_VC0,
  output logic                  rd_enable_VC1,
  output logic [data_width-1:0] data_out,
  output logic                  valid_out,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t state_q;

  // Stage 1 records that a read went out and which channel supplied it.
  // Stage 2 (data_out/valid_out) picks up the FIFO word one cycle later.
  logic pend_q;
  logic sel_q;

  logic grant_ok;
  logic any_read;

  assign state = state_q;

  // Reads are only legal once the FSM is running and the downstream stage
  // can accept data.
  assign grant_ok = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) &&
                    init && !almost_full_dest;

  assign any_read = rd_enable_VC0 || rd_enable_VC1;

`ifdef VC_FAIR_EN
  localparam logic [2:0] burst_limit = 3'(MAX_BURST);

  logic [2:0] burst_cnt;
  logic       force_vc1;

  // After MAX_BURST back-to-back VC0 grants with VC1 waiting, VC1 gets a turn.
  assign force_vc1 = !empty_VC1 && (burst_cnt >= burst_limit);

  // Grant selection with bounded VC0 bursts.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and infers a latch.
    rd_enable_VC0 = 1'b0;
    rd_enable_VC1 = 1'b0;
    if (grant_ok) begin
      rd_enable_VC0 = !empty_VC0 && !force_vc1;
      rd_enable_VC1 = !empty_VC1 && (empty_VC0 || force_vc1);
    end
  end

  // Count consecutive VC0 grants only while VC1 is actually waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt <= 3'd0;
    end else if (!init || (state_q == ST_INIT) || rd_enable_VC1 || empty_VC1) begin
      burst_cnt <= 3'd0;
    end else if (rd_enable_VC0) begin
      burst_cnt <= burst_cnt + 3'd1;
    end
  end
`else
  // Grant selection with strict VC0 priority.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and infers a latch.
    rd_enable_VC0 = 1'b0;
    rd_enable_VC1 = 1'b0;
    if (grant_ok) begin
      rd_enable_VC0 = !empty_VC0;
      rd_enable_VC1 = empty_VC0 && !empty_VC1;
    end
  end
`endif

  // Control FSM. Soft init overrides every state; IDLE/ACTIVE only track
  // whether a read strobe is being issued this cycle.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (!reset) begin
      state_q <= ST_RESET;
    end else if (!init) begin
      state_q <= ST_INIT;
    end else begin
      case (state_q)
        ST_RESET:  state_q <= ST_INIT;
        ST_INIT:   state_q <= ST_IDLE;
        ST_IDLE,
        ST_ACTIVE: state_q <= any_read ? ST_ACTIVE : ST_IDLE;
      endcase
    end
  end

  // Two-stage read pipeline. Init drops anything in flight, matching the
  // FIFOs flushing at the same time. data_out holds when no word arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q    <= 1'b0;
      sel_q     <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (!init) begin
      pend_q    <= 1'b0;
      sel_q     <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      pend_q    <= any_read;
      sel_q     <= rd_enable_VC1;
      valid_out <= pend_q;
      if (pend_q) begin
        data_out <= sel_q ? data_in_VC1 : data_in_VC0;
      end
    end
  end

endmodule

// File: tb/tb_vc_read_arbiter.sv
// Self-checking bench for vc_read_arbiter.
// The bench holds two behavioural FIFOs, which supply the registered read data
// and empty flags, plus a transaction-level model of the arbiter. A negedge
// compare process checks every output on every cycle. Directed scenarios add
// literal expectations for grant order, latency, backpressure, init and reset.

module tb_vc_read_arbiter;

  localparam int DW        = 6;
  localparam int MAX_BURST = 4;

  logic          clk;
  logic          reset;
  logic          init;
  logic          empty_VC0;
  logic          empty_VC1;
  logic [DW-1:0] data_in_VC0;
  logic [DW-1:0] data_in_VC1;
  logic          almost_full_dest;
  logic          rd_enable_VC0;
  logic          rd_enable_VC1;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [1:0]    state;

  vc_read_arbiter #(.data_width(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk              (clk),
    .reset            (reset),
    .init             (init),
    .empty_VC0        (empty_VC0),
    .empty_VC1        (empty_VC1),
    .data_in_VC0      (data_in_VC0),
    .data_in_VC1      (data_in_VC1),
    .almost_full_dest (almost_full_dest),
    .rd_enable_VC0    (rd_enable_VC0),
    .rd_enable_VC1    (rd_enable_VC1),
    .data_out         (data_out),
    .valid_out        (valid_out),
    .state            (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural FIFO contents and arbiter model.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            m_state;    // 0 reset, 1 init, 2 idle, 3 active
  bit            s1_v;       // a word was read last cycle
  logic [DW-1:0] s1_w;       // the word that read returned
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  int            run;        // consecutive VC0 grants while VC1 waits
  bit            chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which FIFO must be read this cycle: 0 none, 1 VC0, 2 VC1.
  function automatic int model_grant();
    if (!(reset && init && !almost_full_dest && m_state >= 2)) return 0;
`ifdef VC_FAIR_EN
    if (!empty_VC1 && run >= MAX_BURST) return 2;
`endif
    if (!empty_VC0) return 1;
    if (!empty_VC1) return 2;
    return 0;
  endfunction

  function automatic void refresh();
    empty_VC0 = (q0.size() == 0);
    empty_VC1 = (q1.size() == 0);
  endfunction

  function automatic void reset_model();
    m_state   = 0;
    s1_v      = 1'b0;
    s1_w      = '0;
    exp_valid = 1'b0;
    exp_data  = '0;
    run       = 0;
    q0.delete();
    q1.delete();
    refresh();
  endfunction

  // One clock: sample pre-edge inputs, then advance FIFOs and model.
  task automatic cyc();
    int            g;
    logic          init_v;
    logic          rst_v;
    logic          e1_v;
    logic [DW-1:0] w;
    @(posedge clk);
    g      = model_grant();
    init_v = init;
    rst_v  = reset;
    e1_v   = empty_VC1;
    #1;
    if (!rst_v) begin
      reset_model();
    end else if (!init_v) begin
      exp_valid = 1'b0;
      exp_data  = '0;
      s1_v      = 1'b0;
      run       = 0;
      m_state   = 1;
      q0.delete();
      q1.delete();
    end else begin
      exp_valid = s1_v;
      if (s1_v) exp_data = s1_w;
      s1_v = (g != 0);
      if (g == 1) begin
        w = q0.pop_front();
        data_in_VC0 = w;
        s1_w = w;
      end else if (g == 2) begin
        w = q1.pop_front();
        data_in_VC1 = w;
        s1_w = w;
      end
      if (g == 2 || e1_v) run = 0;
      else if (g == 1) run++;
      if (m_state == 0)      m_state = 1;
      else if (m_state == 1) m_state = 2;
      else                   m_state = (g != 0) ? 3 : 2;
    end
    refresh();
  endtask

  function automatic logic [3:0] dut_grant();
    return rd_enable_VC0 ? 4'h1 : (rd_enable_VC1 ? 4'h2 : 4'h0);
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin : compare
    int g;
    if (chk_en) begin
      g = model_grant();
      check("rd_enable_VC0", rd_enable_VC0, g == 1);
      check("rd_enable_VC1", rd_enable_VC1, g == 2);
      check("one_hot_rd", rd_enable_VC0 && rd_enable_VC1, 1'b0);
      check("valid_out", valid_out, exp_valid);
      check("data_out", data_out, exp_data);
      check("state", state, m_state[1:0]);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin : main
    logic [63:0]   code;
    logic [15:0]   vb;
    logic [15:0]   sc;
    logic [DW-1:0] got[$];
    logic [DW-1:0] pri_exp[6];

    reset            = 1'b1;
    init             = 1'b1;
    almost_full_dest = 1'b0;
    data_in_VC0      = '0;
    data_in_VC1      = '0;
    #2;
    reset = 1'b0;
    reset_model();
    chk_en = 1'b1;

    // Reset for 3 cycles, then init low for 2 cycles.
    repeat (3) cyc();
    @(negedge clk);
    check("reset_state", state, 2'd0);
    check("reset_valid", valid_out, 1'b0);
    check("reset_data", data_out, '0);
    #4;
    reset = 1'b1;
    init  = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    check("init_state", state, 2'd1);
    check("init_rd", {rd_enable_VC0, rd_enable_VC1}, 2'b00);
    #4;
    init = 1'b1;
    cyc();
    @(negedge clk);
    check("idle_state", state, 2'd2);
    cyc();

    // A single VC1 word: one strobe, then the word two cycles later.
    q1.push_back(6'h2A);
    refresh();
    @(negedge clk);
    check("single_rd1_on", rd_enable_VC1, 1'b1);
    cyc();
    @(negedge clk);
    check("single_rd1_off", rd_enable_VC1, 1'b0);
    check("single_valid_t1", valid_out, 1'b0);
    cyc();
    @(negedge clk);
    check("single_valid_t2", valid_out, 1'b1);
    check("single_data_t2", data_out, 6'h2A);
    cyc();
    @(negedge clk);
    check("single_valid_t3", valid_out, 1'b0);
    repeat (2) cyc();

    // Priority: three words in each FIFO.
    q0 = '{6'h01, 6'h02, 6'h03};
    q1 = '{6'h11, 6'h12, 6'h13};
    refresh();
    pri_exp = '{6'h01, 6'h02, 6'h03, 6'h11, 6'h12, 6'h13};
    code = '0;
    vb   = '0;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      code = {code[59:0], dut_grant()};
      vb   = {vb[14:0], valid_out};
      if (valid_out) got.push_back(data_out);
      cyc();
    end
    check("prio_grant_order", code[31:0], 32'h11122200);
    check("prio_valid_run", vb[7:0], 8'b00111111);
    check("prio_word_count", got.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) check($sformatf("prio_word%0d", i), got[i], pri_exp[i]);
    end
    repeat (2) cyc();

    // Backpressure for 4 cycles in the middle of an 8-word VC0 burst.
    q0.delete();
    for (int k = 0; k < 8; k++) q0.push_back(DW'(6'h20 + k));
    refresh();
    code = '0;
    vb   = '0;
    got.delete();
    for (int i = 0; i < 14; i++) begin
      if (i == 3) almost_full_dest = 1'b1;
      if (i == 7) almost_full_dest = 1'b0;
      @(negedge clk);
      code = {code[59:0], dut_grant()};
      vb   = {vb[14:0], valid_out};
      if (valid_out) got.push_back(data_out);
      cyc();
    end
    check("bp_grant_order", code[55:0], 56'h11100001111100);
    check("bp_valid_pattern", vb[13:0], 14'b00111000011111);
    check("bp_word_count", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) check($sformatf("bp_word%0d", i), got[i], DW'(6'h20 + i));
    end
    repeat (2) cyc();

`ifdef VC_FAIR_EN
    // Fair mode: 10 VC0 words against 2 VC1 words.
    q0.delete();
    for (int k = 0; k < 10; k++) q0.push_back(DW'(k));
    q1 = '{6'h38, 6'h39};
    refresh();
    code = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      code = {code[59:0], dut_grant()};
      cyc();
    end
    check("fair_grant_order", code[47:0], 48'h111121111211);
    repeat (4) cyc();
`endif

    // Init mid-stream with two words in flight.
    q0.delete();
    for (int k = 0; k < 6; k++) q0.push_back(DW'(6'h30 + k));
    refresh();
    code = '0;
    vb   = '0;
    sc   = '0;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (i == 2) init = 1'b0;
      if (i == 4) init = 1'b1;
      @(negedge clk);
      code = {code[59:0], dut_grant()};
      vb   = {vb[14:0], valid_out};
      sc   = {sc[13:0], state};
      if (valid_out) got.push_back(data_out);
      if (i == 3) check("init_flush_data", data_out, '0);
      cyc();
    end
    check("init_grant_order", code[31:0], 32'h11000000);
    check("init_valid_pattern", vb[7:0], 8'b00100000);
    check("init_state_trace", sc, 16'b1011110101101010);
    check("init_word_count", got.size(), 1);
    if (got.size() > 0) check("init_word0", got[0], 6'h30);
    q0.push_back(6'h3F);
    refresh();
    got.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (valid_out) got.push_back(data_out);
      cyc();
    end
    check("post_init_count", got.size(), 1);
    if (got.size() > 0) check("post_init_word", got[0], 6'h3F);

    // Asynchronous reset in the middle of a stream.
    q0 = '{6'h05, 6'h06, 6'h07, 6'h08};
    refresh();
    repeat (2) cyc();
    @(negedge clk);
    check("pre_reset_valid", valid_out, 1'b1);
    check("pre_reset_data", data_out, 6'h05);
    #4;
    reset = 1'b0;
    reset_model();
    #1;
    check("async_rst_state", state, 2'd0);
    check("async_rst_rd0", rd_enable_VC0, 1'b0);
    check("async_rst_valid", valid_out, 1'b0);
    check("async_rst_data", data_out, '0);
    cyc();
    reset = 1'b1;
    cyc();
    @(negedge clk);
    check("rst_release_init", state, 2'd1);
    cyc();
    @(negedge clk);
    check("rst_release_idle", state, 2'd2);
    repeat (2) cyc();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
